// File: rtl/aia_src_gateway_if.sv
// rtl/aia_src_gateway_if.sv - source/pending signal bundle between pins, software and the gateway
//
// Purpose: groups the per-source wires of the APLIC source gateway.
// Ports (signals):
//   src_i    NR_SRC      raw asynchronous source wires
//   mode_i   NR_SRC x 3  per-source source mode (SM)
//   swset_i  NR_SRC      software set-pending pulse
//   clr_i    NR_SRC      claim/clear-pending pulse
//   rect_o   NR_SRC      registered rectified input value
//   pend_o   NR_SRC      pending bits
//   edge_o   NR_SRC      one-cycle hardware-edge pulse
// Modports: master drives sources/controls, slave is the gateway.
interface aia_src_gateway_if #(
  parameter int unsigned NR_SRC = 32
);
  logic [NR_SRC-1:0]      src_i;
  logic [NR_SRC-1:0][2:0] mode_i;
  logic [NR_SRC-1:0]      swset_i;
  logic [NR_SRC-1:0]      clr_i;
  logic [NR_SRC-1:0]      rect_o;
  logic [NR_SRC-1:0]      pend_o;
  logic [NR_SRC-1:0]      edge_o;

  modport master (
    output src_i, mode_i, swset_i, clr_i,
    input  rect_o, pend_o, edge_o
  );

  modport slave (
    input  src_i, mode_i, swset_i, clr_i,
    output rect_o, pend_o, edge_o
  );
endinterface

// File: rtl/aia_src_gateway.sv
// rtl/aia_src_gateway.sv - multi-channel APLIC interrupt-source gateway
//
// Purpose: synchronises each raw source wire, rectifies it per its source
// mode, detects edges and maintains a per-source pending bit that software
// can set and the claim logic can clear.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   gw      aia_src_gateway_if.slave (src_i/mode_i/swset_i/clr_i in,
//           rect_o/pend_o/edge_o out)
module aia_src_gateway #(
  parameter int unsigned NR_SRC      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  aia_src_gateway_if.slave   gw
);

  localparam logic [2:0] SM_DETACHED = 3'd1;
  localparam logic [2:0] SM_EDGE1    = 3'd4;
  localparam logic [2:0] SM_EDGE0    = 3'd5;
  localparam logic [2:0] SM_LEVEL1   = 3'd6;
  localparam logic [2:0] SM_LEVEL0   = 3'd7;

  // raw_prev only holds a genuine source sample once the synchroniser has
  // been refilled after reset; until then edges are masked so a source held
  // active through reset does not look like a fresh edge.
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [NR_SRC-1:0] raw;
  logic [NR_SRC-1:0] raw_prev_q;
  logic [NR_SRC-1:0] rect;
  logic [NR_SRC-1:0] pend_d, pend_q;
  logic [NR_SRC-1:0] edge_d, edge_q;
  logic [NR_SRC-1:0] rect_q;
  logic [NR_SRC-1:0] rise, fall;
  logic [2:0]        warm_q;
  logic              edge_en;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign raw = gw.src_i;
    end else begin : g_sync
      logic [NR_SRC-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= gw.src_i;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end

      assign raw = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign edge_en = (warm_q == WARM_MAX);
  assign rise    = raw & ~raw_prev_q & {NR_SRC{edge_en}};
  assign fall    = ~raw & raw_prev_q & {NR_SRC{edge_en}};

  always_comb begin
    rect   = '0;
    pend_d = '0;
    edge_d = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      unique case (gw.mode_i[i])
        SM_DETACHED: begin
          pend_d[i] = gw.swset_i[i] | (~gw.clr_i[i] & pend_q[i]);
        end
        SM_EDGE1: begin
          rect[i]   = raw[i];
          edge_d[i] = rise[i];
          // set beats a simultaneous clear so a new edge is never lost
          pend_d[i] = rise[i] | gw.swset_i[i] | (~gw.clr_i[i] & pend_q[i]);
        end
        SM_EDGE0: begin
          rect[i]   = ~raw[i];
          edge_d[i] = fall[i];
          pend_d[i] = fall[i] | gw.swset_i[i] | (~gw.clr_i[i] & pend_q[i]);
        end
        SM_LEVEL1: begin
          rect[i]   = raw[i];
          pend_d[i] = raw[i];
        end
        SM_LEVEL0: begin
          rect[i]   = ~raw[i];
          pend_d[i] = ~raw[i];
        end
        default: begin
          rect[i]   = 1'b0;
          pend_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_prev_q <= '0;
      pend_q     <= '0;
      edge_q     <= '0;
      rect_q     <= '0;
      warm_q     <= '0;
    end else begin
      raw_prev_q <= raw;
      pend_q     <= pend_d;
      edge_q     <= edge_d;
      rect_q     <= rect;
      if (!edge_en) warm_q <= warm_q + 3'd1;
    end
  end

  assign gw.pend_o = pend_q;
  assign gw.edge_o = edge_q;
  assign gw.rect_o = rect_q;

endmodule

// File: tb/tb_aia_src_gateway.sv
// tb/tb_aia_src_gateway.sv - self-checking bench for aia_src_gateway
module tb_aia_src_gateway;
  localparam int N = 32;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aia_src_gateway_if #(.NR_SRC(N)) bus ();

  aia_src_gateway #(.NR_SRC(N), .SYNC_STAGES(S)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .gw    (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [N-1:0] m_pend, m_edge, m_rect;
  logic [N-1:0] hist[$];   // hist[k] = src sampled k+1 edges ago
  int           m_age;     // edges since reset release

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] raw, prev;
    logic ev;
    if (!rst_n) begin
      m_pend = '0; m_edge = '0; m_rect = '0; m_age = 0;
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back('0);
      return;
    end
    raw  = hist[S-1];
    prev = hist[S];
    for (int i = 0; i < N; i++) begin
      m_edge[i] = 1'b0;
      case (bus.mode_i[i])
        3'd1: begin
          m_rect[i] = 1'b0;
          m_pend[i] = bus.swset_i[i] ? 1'b1 : bus.clr_i[i] ? 1'b0 : m_pend[i];
        end
        3'd4, 3'd5: begin
          m_rect[i] = (bus.mode_i[i] == 3'd4) ? raw[i] : !raw[i];
          ev = (m_age >= S + 1) && (raw[i] != prev[i]) && (m_rect[i] == 1'b1);
          m_edge[i] = ev;
          m_pend[i] = (ev || bus.swset_i[i]) ? 1'b1 : bus.clr_i[i] ? 1'b0 : m_pend[i];
        end
        3'd6: begin m_rect[i] = raw[i];  m_pend[i] = raw[i];  end
        3'd7: begin m_rect[i] = !raw[i]; m_pend[i] = !raw[i]; end
        default: begin m_rect[i] = 1'b0; m_pend[i] = 1'b0; end
      endcase
    end
    hist.push_front(bus.src_i);
    void'(hist.pop_back());
    if (m_age < 100) m_age++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pend", bus.pend_o, m_pend);
    chk("edge", bus.edge_o, m_edge);
    chk("rect", bus.rect_o, m_rect);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_modes(input logic [2:0] m);
    for (int i = 0; i < N; i++) bus.mode_i[i] = m;
  endtask

  initial begin
    bus.src_i = '1; bus.swset_i = '0; bus.clr_i = '0;
    set_modes(3'd4);

    // 1: sources high through reset, no spurious pending
    rst_n = 1'b0;
    ticks(3);
    chk("rst_pend", bus.pend_o, '0);
    chk("rst_rect0", bus.rect_o, '0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rst_no_pend", bus.pend_o, '0);
      if (k == S + 1) chk("rst_rect1", bus.rect_o, {N{1'b1}});
    end

    // 2: Edge1 on src[3]
    bus.src_i = '0; ticks(4);
    bus.src_i[3] = 1'b1;
    ticks(2);
    chk("e1_pend_early", bus.pend_o[3], 1'b0);
    tick();
    chk("e1_edge", bus.edge_o[3], 1'b1);
    chk("e1_pend", bus.pend_o[3], 1'b1);
    ticks(3);
    chk("e1_no_second", bus.edge_o[3], 1'b0);
    bus.clr_i[3] = 1'b1; tick(); bus.clr_i[3] = 1'b0;
    chk("e1_clr", bus.pend_o[3], 1'b0);

    // 3: Edge0 on src[5], clear on the same edge as a new fall
    bus.mode_i[5] = 3'd5; bus.src_i[5] = 1'b1; ticks(4);
    bus.src_i[5] = 1'b0; ticks(2);
    bus.clr_i[5] = 1'b1; tick(); bus.clr_i[5] = 1'b0;
    chk("e0_set_wins", bus.pend_o[5], 1'b1);

    // 4: Level0 on src[7]
    bus.mode_i[7] = 3'd7; bus.src_i[7] = 1'b0; ticks(3);
    chk("l0_pend", bus.pend_o[7], 1'b1);
    bus.clr_i[7] = 1'b1; tick(); bus.clr_i[7] = 1'b0;
    chk("l0_clr_ignored", bus.pend_o[7], 1'b1);
    bus.src_i[7] = 1'b1; ticks(3);
    chk("l0_drop", bus.pend_o[7], 1'b0);
    bus.swset_i[7] = 1'b1; tick(); bus.swset_i[7] = 1'b0;
    chk("l0_swset_ignored", bus.pend_o[7], 1'b0);

    // 5: detached src[9]
    bus.mode_i[9] = 3'd1;
    for (int k = 0; k < 6; k++) begin bus.src_i[9] = ~bus.src_i[9]; tick(); end
    chk("det_toggle", bus.pend_o[9], 1'b0);
    bus.swset_i[9] = 1'b1; tick(); bus.swset_i[9] = 1'b0;
    chk("det_swset", bus.pend_o[9], 1'b1);
    bus.clr_i[9] = 1'b1; tick(); bus.clr_i[9] = 1'b0;
    chk("det_clr", bus.pend_o[9], 1'b0);
    bus.swset_i[9] = 1'b1; tick(); bus.swset_i[9] = 1'b0;
    bus.mode_i[9] = 3'd0; tick();
    chk("det_inactive", bus.pend_o[9], 1'b0);

    // 6: Edge1 -> Edge0 with src steady high
    bus.src_i[3] = 1'b1; ticks(4);
    bus.mode_i[3] = 3'd5; tick();
    chk("msw_no_edge", bus.edge_o[3], 1'b0);

    // randomized traffic against the model, occasional resets
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0)
        for (int i = 0; i < N; i++) bus.mode_i[i] = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 149) != 0);
      bus.src_i   = bus.src_i ^ ($urandom & $urandom);
      bus.swset_i = $urandom & $urandom & $urandom;
      bus.clr_i   = $urandom & $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
